// File: rtl/cache_fill_arbiter_if.sv
// Cache-port / memory bundle for cache_fill_arbiter.
// master = cache ports + memory side, slave = the arbiter.
interface cache_fill_arbiter_if #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);

    logic [NUM_PORTS-1:0]        req_fill;
    logic [NUM_PORTS-1:0]        req_wr;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        grant;
    logic [NUM_PORTS-1:0]        busy;
    logic                        fill_we;
    logic [OFF_W-1:0]            fill_word;
    logic [DATA_W-1:0]           fill_data;
    logic [NUM_PORTS-1:0]        fill_done;
    logic [NUM_PORTS-1:0]        wr_done;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_en;
    logic                        mem_wr;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_valid;

    modport master (
        output req_fill, req_wr, req_addr, req_wdata,
        output mem_rdata, mem_valid,
        input  grant, busy, fill_we, fill_word, fill_data,
        input  fill_done, wr_done,
        input  mem_addr, mem_wdata, mem_en, mem_wr
    );

    modport slave (
        input  req_fill, req_wr, req_addr, req_wdata,
        input  mem_rdata, mem_valid,
        output grant, busy, fill_we, fill_word, fill_data,
        output fill_done, wr_done,
        output mem_addr, mem_wdata, mem_en, mem_wr
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Round-robin block-fill / write-through front end to a pipelined memory.
// Define CFA_CRITICAL_WORD_FIRST_EN to start each fill at the requested word.
module cache_fill_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    cache_fill_arbiter_if.slave bus
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [OFF_W-1:0]  LAST     = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE,
        S_WRITE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_rr, w_rr_nxt;
    logic [PTR_W-1:0]     r_own, w_own_nxt;
    logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
    logic [ADDR_W-1:0]    r_base, w_base_nxt;
    logic [OFF_W-1:0]     r_iss, w_iss_nxt;
    logic [OFF_W-1:0]     r_rcv, w_rcv_nxt;
    logic                 r_iss_end, w_iss_end_nxt;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_hit;
    logic [PTR_W-1:0]     w_pick;
    logic [PTR_W-1:0]     w_idx;
    logic [ADDR_W-1:0]    w_pick_addr;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [OFF_W-1:0]     w_iss_word;
    logic [OFF_W-1:0]     w_rcv_word;

    logic                 w_mem_en;
    logic                 w_mem_wr;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic [DATA_W-1:0]    w_mem_wdata;
    logic                 w_fill_we;
    logic [NUM_PORTS-1:0] w_fill_done;
    logic [NUM_PORTS-1:0] w_wr_done;

    assign w_req = bus.req_fill | bus.req_wr;

    // First requester at or after the round-robin pointer wins.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = PTR_W'((int'(r_rr) + k) % NUM_PORTS);
            if (!w_hit && w_req[w_idx]) begin
                w_hit  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_pick_addr = bus.req_addr[int'(w_pick) * ADDR_W +: ADDR_W];
    assign w_sel_addr  = bus.req_addr[int'(r_own) * ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.req_wdata[int'(r_own) * DATA_W +: DATA_W];

`ifdef CFA_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] r_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= '0;
        end else if (r_state == S_IDLE && w_hit) begin
            r_start <= w_pick_addr[OFF_W:1];
        end
    end

    assign w_iss_word = r_start + r_iss;
    assign w_rcv_word = r_start + r_rcv;
`else
    assign w_iss_word = r_iss;
    assign w_rcv_word = r_rcv;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr;
        w_own_nxt     = r_own;
        w_grant_nxt   = r_grant;
        w_base_nxt    = r_base;
        w_iss_nxt     = r_iss;
        w_rcv_nxt     = r_rcv;
        w_iss_end_nxt = r_iss_end;
        w_mem_en      = 1'b0;
        w_mem_wr      = 1'b0;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        w_fill_we     = 1'b0;
        w_fill_done   = '0;
        w_wr_done     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_own_nxt     = w_pick;
                    w_rr_nxt      = PTR_W'((int'(w_pick) + 1) % NUM_PORTS);
                    w_grant_nxt   = NUM_PORTS'(1) << w_pick;
                    w_base_nxt    = w_pick_addr & BLK_MASK;
                    w_iss_nxt     = '0;
                    w_rcv_nxt     = '0;
                    w_iss_end_nxt = 1'b0;
                    w_state_nxt   = bus.req_fill[w_pick] ? S_FILL : S_WRITE;
                end
            end
            S_FILL: begin
                if (!r_iss_end) begin
                    w_mem_en   = 1'b1;
                    w_mem_addr = r_base | (ADDR_W'(w_iss_word) << 1);
                    w_iss_nxt  = r_iss + 1'b1;
                    if (r_iss == LAST) begin
                        w_iss_end_nxt = 1'b1;
                    end
                end
                // Returns are counted independently of issue progress.
                if (bus.mem_valid) begin
                    w_fill_we = 1'b1;
                    w_rcv_nxt = r_rcv + 1'b1;
                    if (r_rcv == LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_fill_done = r_grant;
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            S_WRITE: begin
                w_mem_en    = 1'b1;
                w_mem_wr    = 1'b1;
                w_mem_addr  = w_sel_addr;
                w_mem_wdata = w_sel_wdata;
                w_wr_done   = r_grant;
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr      <= '0;
            r_own     <= '0;
            r_grant   <= '0;
            r_base    <= '0;
            r_iss     <= '0;
            r_rcv     <= '0;
            r_iss_end <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr      <= w_rr_nxt;
            r_own     <= w_own_nxt;
            r_grant   <= w_grant_nxt;
            r_base    <= w_base_nxt;
            r_iss     <= w_iss_nxt;
            r_rcv     <= w_rcv_nxt;
            r_iss_end <= w_iss_end_nxt;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.fill_we   = w_fill_we;
    assign bus.fill_word = w_fill_we ? w_rcv_word : '0;
    assign bus.fill_data = w_fill_we ? bus.mem_rdata : '0;
    assign bus.fill_done = w_fill_done;
    assign bus.wr_done   = w_wr_done;
    assign bus.busy      = (bus.req_fill & ~w_fill_done)
                         | (bus.req_wr & ~w_wr_done);
endmodule
